// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory access unit: op/size encodings,
// FSM states and per-op decode functions.
package mem_access_unit_pkg;

    typedef enum logic [3:0] {
        MOP_NONE, MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW, MOP_LWU, MOP_LD,
        MOP_SB, MOP_SH, MOP_SW, MOP_SD
    } mem_op_t;

    // Encoded as log2 of the access size in bytes.
    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

    function automatic msize_t op_size(input mem_op_t op);
        case (op)
            MOP_LH, MOP_LHU, MOP_SH: return MSIZE2;
            MOP_LW, MOP_LWU, MOP_SW: return MSIZE4;
            MOP_LD, MOP_SD:          return MSIZE8;
            default:                 return MSIZE1;
        endcase
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW) || (op == MOP_SD);
    endfunction

    function automatic logic op_is_signed(input mem_op_t op);
        return (op == MOP_LB) || (op == MOP_LH) || (op == MOP_LW) || (op == MOP_LD);
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_amask(input msize_t s);
        return 3'((4'd1 << s) - 4'd1);
    endfunction

    // Byte-enable pattern for an access at lane 0.
    function automatic logic [7:0] size_bmask(input msize_t s);
        case (s)
            MSIZE1:  return 8'h01;
            MSIZE2:  return 8'h03;
            MSIZE4:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus request/response bundle between the memory access unit (master)
// and the memory system (slave).
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic                dreq_valid;
    logic [31:0]         dreq_addr;
    msize_t              dreq_size;
    logic [DATA_W/8-1:0] dreq_strobe;
    logic [DATA_W-1:0]   dreq_data;
    logic                dresp_addr_ok;
    logic                dresp_data_ok;
    logic [DATA_W-1:0]   dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/mem_access_unit_load_extract.sv
// Combinational load-data extraction: picks the addressed byte lane out of
// the raw bus word and sign- or zero-extends it to the full register width.
module load_extract
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [LANE_W-1:0] lane,
    input  mem_op_t           op,
    output logic [DATA_W-1:0] result
);
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              msb;

    // Align the lane to bit 0, keep the access width, fill upper bits with sign or zero.
    always_comb begin
        shifted = raw >> {lane, 3'b000};
        keep    = '1;
        msb     = 1'b0;
        case (op_size(op))
            MSIZE1: begin keep = DATA_W'(8'hFF);         msb = shifted[7];  end
            MSIZE2: begin keep = DATA_W'(16'hFFFF);      msb = shifted[15]; end
            MSIZE4: begin keep = DATA_W'(32'hFFFF_FFFF); msb = shifted[31]; end
            default: ;
        endcase
        result = (shifted & keep) | ((op_is_signed(op) && msb) ? ~keep : '0);
    end
endmodule

// File: rtl/mem_access_unit.sv
// Memory pipeline stage: accepts one load/store/pass-through op, runs it over
// the addr_ok/data_ok data bus, and hands the extended result to writeback.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 5,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  mem_op_t           in_op,
    input  logic [31:0]       in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_exc,
    mem_access_unit_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);

    state_t            state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              exc_q, exc_d;

    mem_op_t           in_op_legal;
    logic [2:0]        in_amask;
    logic              in_misaligned;
    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] load_result;

    assign lane = addr_q[LANE_W-1:0];

    load_extract #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_extract (
        .raw    (bus.dresp_data),
        .lane   (lane),
        .op     (op_q),
        .result (load_result)
    );

    // Decode the incoming op: 64-bit-only ops degrade to pass-through on a 32-bit bus.
    always_comb begin
        in_op_legal = in_op;
        if (DATA_W < 64 && (in_op == MOP_LWU || in_op == MOP_LD || in_op == MOP_SD))
            in_op_legal = MOP_NONE;
        in_amask      = size_amask(op_size(in_op_legal));
        in_misaligned = |(in_addr[2:0] & in_amask);
    end

    // Next-state and datapath capture for the request/response FSM.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        tag_d   = tag_q;
        exc_d   = exc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op_legal;
                    wdata_d = in_wdata;
                    tag_d   = in_tag;
                    addr_d  = (in_misaligned && !ALIGN_CHECK) ? (in_addr & ~{29'd0, in_amask})
                                                              : in_addr;
                    exc_d   = 1'b0;
                    data_d  = '0;
                    if (in_op_legal == MOP_NONE) begin
                        data_d  = DATA_W'(in_addr);
                        state_d = ST_DONE;
                    end else if (in_misaligned && ALIGN_CHECK) begin
                        exc_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // A data_ok without addr_ok implies the address was taken too.
                if (bus.dresp_data_ok) begin
                    data_d  = op_is_store(op_q) ? '0 : load_result;
                    state_d = ST_DONE;
                end else if (bus.dresp_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.dresp_data_ok) begin
                    data_d  = op_is_store(op_q) ? '0 : load_result;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured-op registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= MOP_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            exc_q   <= exc_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = data_q;
    assign out_tag   = tag_q;
    assign out_exc   = exc_q;

    // Request fields come straight from the registers so they hold until addr_ok.
    assign bus.dreq_valid  = (state_q == ST_REQ);
    assign bus.dreq_addr   = addr_q;
    assign bus.dreq_size   = op_size(op_q);
    assign bus.dreq_strobe = (state_q == ST_REQ && op_is_store(op_q))
                             ? (STRB_W'(size_bmask(op_size(op_q))) << lane) : '0;
    assign bus.dreq_data   = wdata_q << {lane, 3'b000};
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised, handshaked successor to the combinational memory stage.
- Accepts one load/store/pass-through op from the execute→memory pipeline register and drives the data bus with a valid/addr_ok/data_ok handshake.
- Extracts and sign- or zero-extends load data, detects misaligned addresses, and presents a result to writeback through a valid/ready handshake.
- Sits between the execute→memory register and the memory→writeback register; its `in_ready` back-pressures the pipeline.

Parameters:
- DATA_W, 32: bus/register width; legal values 32 or 64. 64 enables the LWU, LD and SD ops.
- TAG_W, 5: width of the destination-register tag carried through.
- ALIGN_CHECK, 1: 1 = raise an address exception on misaligned access; 0 = force the address down to natural alignment.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  unit can accept an op
- in_op  in  mem_op_t  MOP_NONE/LB/LBU/LH/LHU/LW/LWU/LD/SB/SH/SW/SD
- in_addr  in  32  effective byte address (valE)
- in_wdata  in  DATA_W  store data (valA)
- in_tag  in  TAG_W  destination register
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  extended load data, or in_addr zero-extended for MOP_NONE
- out_tag  out  TAG_W  captured tag
- out_exc  out  1  address error (adel for loads, ades for stores)
- dreq_valid  out  1  bus request
- dreq_addr  out  32  byte address
- dreq_size  out  msize_t  MSIZE1/2/4/8
- dreq_strobe  out  DATA_W/8  byte write enables; all 0 for loads
- dreq_data  out  DATA_W  store data shifted to its byte lane
- dresp_addr_ok  in  1  address accepted
- dresp_data_ok  in  1  data returned / write done
- dresp_data  in  DATA_W  read data

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high on `reset`, sampled on the rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_exc=0, out_data=0, out_tag=0, dreq_valid=0, dreq_strobe=0.
- States:
  - IDLE: in_ready=1.
  - REQ: dreq_valid=1.
  - WAIT: waiting for data_ok.
  - DONE: out_valid=1.
- Accept: in IDLE with in_valid=1, register op, addr, wdata and tag.
  - MOP_NONE → DONE next cycle.
  - Misaligned with ALIGN_CHECK=1 → DONE with out_exc=1 and out_data=0. No bus request is issued.
  - Otherwise → REQ.
- REQ: dreq_* is driven from the registers and held stable until addr_ok.
  - addr_ok & data_ok in the same cycle → DONE.
  - addr_ok only → WAIT.
  - Neither → stay in REQ.
- WAIT: dreq_valid=0. data_ok → DONE.
- Load data capture: on data_ok, capture dresp_data.
  - Select lane `addr[log2(DATA_W/8)-1:0]`.
  - Extend per op: B/H/W sign-extend; BU/HU/WU zero-extend.
- DONE: out_valid=1, held until out_ready=1. Then → IDLE.
  - Accept is not overlapped in DONE; in_ready is 0 in every state except IDLE.
- Latency (accept in cycle N):
  - Pass-through or exception: out_valid at N+1.
  - Best-case bus access (addr_ok & data_ok at N+1): out_valid at N+2.
- Alignment rule: misaligned when addr mod size ≠ 0, for sizes 2, 4 and 8.
  - With ALIGN_CHECK=0, the low address bits are cleared instead.
- Store lane placement: strobe = ((1<<size)-1) << lane. dreq_data = wdata replicated/shifted into the lane. Unselected bytes are don't-care.
- dreq_addr is the full byte address, not word-cleared.
- Reset mid-transaction: return to IDLE next cycle and drop dreq_valid. A late data_ok arriving in IDLE is ignored.
- Bus-protocol errors:
  - data_ok in REQ without addr_ok is treated as addr_ok & data_ok.
  - addr_ok/data_ok in IDLE or DONE are ignored.
- DATA_W=32: LWU, LD and SD are illegal and are treated as MOP_NONE.

Decomposition:
- Shared package (added to defs): mem_op_t enum, msize_t, and helper functions op_size(), op_is_store(), op_is_signed().
- One sub-module `load_extract` (combinational): inputs are raw data, lane offset and op; output is the extended DATA_W result. The FSM, registers and strobe generation stay in mem_access_unit.

Test Plan:
1. LW, addr 0x1000, bus returns 0x8000_00F0 with addr_ok & data_ok in the first REQ cycle → dreq_size=MSIZE4, strobe=0000; out_valid at N+2; out_data=0x8000_00F0.
2. LB addr 0x1003, then LBU same address; dresp_data=0x80AA_BBCC, 3-cycle data_ok delay → out_data=0xFFFF_FF80 and 0x0000_0080; out_valid held with out_ready=0 for 2 cycles; dreq_addr stable while waiting for addr_ok.
3. SH addr 0x2002, wdata 0x1234_ABCD → strobe=1100, dreq_data[31:16]=0xABCD; SB addr 0x2001, wdata 0x55 → strobe=0010.
4. LW addr 0x1002 with ALIGN_CHECK=1 → no dreq_valid; out_exc=1 at N+1. Same stimulus with ALIGN_CHECK=0 → dreq_addr=0x1000.
5. MOP_NONE, addr 0xDEAD_BEEF, tag 7 → out_valid at N+1; out_data=0xDEAD_BEEF; out_tag=7; no bus activity.
6. Assert reset while in WAIT, then inject a stray data_ok one cycle later → state IDLE, all outputs at reset values, no spurious out_valid. With DATA_W=64: LD addr 0x8 → MSIZE8, strobe=0xFF.
